// File: rtl/complex_gate_seq.sv
// Exhaustive stimulus sequencer and checker for the gate_ao / gate_aoi pair.
// Optional macro COMPLEX_GATE_SEQ_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module complex_gate_seq #(
   parameter int WIDTH = 3,
   parameter int HOLD  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] vec,
   input  logic             dut_ao,
   input  logic             dut_aoi,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH+1:0] err_count,
   output logic [WIDTH-1:0] fail_vec
);

   localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic             exp_ao, exp_aoi;
   logic             mm_ao, mm_aoi, any_mm;
   logic             sample, last_vec, stop;
   logic [WIDTH+1:0] err_sum;

   // Case inequality so that x/z on a gate output is scored as a mismatch.
   always_comb begin
      exp_ao   = (&vec[WIDTH-2:0]) | vec[WIDTH-1];
      exp_aoi  = ~exp_ao;
      mm_ao    = (dut_ao !== exp_ao);
      mm_aoi   = (dut_aoi !== exp_aoi);
      any_mm   = mm_ao | mm_aoi;
      err_sum  = err_count + {{(WIDTH+1){1'b0}}, mm_ao} + {{(WIDTH+1){1'b0}}, mm_aoi};
      sample   = (state == RUN) && (hold_cnt == CNT_LAST);
      last_vec = &vec;
`ifdef COMPLEX_GATE_SEQ_STOP_ON_FAIL_EN
      stop     = last_vec | any_mm;
`else
      stop     = last_vec;
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = RUN;
         RUN:        if (sample && stop) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         vec       <= '0;
         hold_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  vec       <= '0;
                  hold_cnt  <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_vec  <= '0;
               end
            end
            RUN: begin
               if (!sample) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end else begin
                  err_count <= err_sum;
                  hold_cnt  <= '0;
                  // A zero running count means no earlier vector has failed this sweep.
                  if (any_mm && (err_count == '0)) fail_vec <= vec;
                  if (stop) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                     pass <= (err_sum == '0);
                  end else begin
                     vec <= vec + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_complex_gate_seq.sv
// Randomized bench for complex_gate_seq: a fault table corrupts the modelled gates,
// and a sweep-level model predicts timing, error count and first failing vector.
module tb_complex_gate_seq;

   localparam int WIDTH = 3;
   localparam int HOLD  = 10;
   localparam int NV    = 1 << WIDTH;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] vec;
   logic             dut_ao, dut_aoi;
   logic             busy, done, pass;
   logic [WIDTH+1:0] err_count;
   logic [WIDTH-1:0] fail_vec;

   bit flip_ao  [NV];
   bit flip_aoi [NV];

   int n_tests = 0;
   int n_fail  = 0;

   complex_gate_seq #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vec       (vec),
      .dut_ao    (dut_ao),
      .dut_aoi   (dut_aoi),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec)
   );

   always #5 clk = ~clk;

   // AO is true when every bit below the top is one, or the top bit is one.
   function automatic bit ao_ref(input int v);
      int low_mask;
      low_mask = (NV / 2) - 1;
      return ((v & low_mask) == low_mask) || (v >= NV / 2);
   endfunction

   always_comb begin
      dut_ao  = ao_ref(int'(vec)) ^ flip_ao[vec];
      dut_aoi = ~ao_ref(int'(vec)) ^ flip_aoi[vec];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_vec"},  32'(vec),       0);
      check({tag, "_busy"}, 32'(busy),      0);
      check({tag, "_done"}, 32'(done),      0);
      check({tag, "_pass"}, 32'(pass),      0);
      check({tag, "_err"},  32'(err_count), 0);
      check({tag, "_fv"},   32'(fail_vec),  0);
   endtask

   task automatic set_faults(input int mode);
      for (int v = 0; v < NV; v++) begin
         case (mode)
            0: begin flip_ao[v] = 1'b0;        flip_aoi[v] = 1'b0; end
            1: begin flip_ao[v] = ao_ref(v);   flip_aoi[v] = 1'b0; end
            2: begin flip_ao[v] = 1'b1;        flip_aoi[v] = 1'b1; end
            default: begin
               flip_ao[v]  = ($urandom_range(0, 7) == 0);
               flip_aoi[v] = ($urandom_range(0, 7) == 0);
            end
         endcase
      end
   endtask

   task automatic run_sweep(input string tag, input bit keep_start);
      int e_err, e_fv, e_last, e_end;
      bit found;
      e_err  = 0;
      e_fv   = 0;
      e_last = NV - 1;
      found  = 0;
      for (int v = 0; v < NV; v++) begin
         int m;
         m = int'(flip_ao[v]) + int'(flip_aoi[v]);
         e_err += m;
         if (m != 0 && !found) begin
            found = 1;
            e_fv  = v;
`ifdef COMPLEX_GATE_SEQ_STOP_ON_FAIL_EN
            e_last = v;
            break;
`endif
         end
      end
      e_end = (e_last + 1) * HOLD;

      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 if (!keep_start) start = 1'b0;
      for (int n = 0; n < e_end; n++) begin
         @(negedge clk);
         check({tag, "_vec"},  32'(vec),  32'(n / HOLD));
         check({tag, "_busy"}, 32'(busy), 1);
         check({tag, "_done"}, 32'(done), 0);
         @(posedge clk);
      end
      @(negedge clk);
      check({tag, "_end_done"}, 32'(done),      1);
      check({tag, "_end_busy"}, 32'(busy),      0);
      check({tag, "_end_pass"}, 32'(pass),      32'(e_err == 0));
      check({tag, "_end_err"},  32'(err_count), 32'(e_err));
      check({tag, "_end_fv"},   32'(fail_vec),  32'(e_fv));
      check({tag, "_end_vec"},  32'(vec),       32'(e_last));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      set_faults(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("rst");
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      set_faults(0); run_sweep("good", 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("done_hold", 32'(done), 1);
      check("done_pass", 32'(pass), 1);

      set_faults(1); run_sweep("ao0", 1'b0);
      set_faults(2); run_sweep("inv", 1'b0);

      set_faults(0);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (34) @(posedge clk);
      @(negedge clk);
      check("mid_vec", 32'(vec), 3);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_state("midrst");
      rst_n = 1'b1;
      run_sweep("restart", 1'b0);

      run_sweep("held", 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("held_re_vec",  32'(vec),  0);
      check("held_re_busy", 32'(busy), 1);
      check("held_re_done", 32'(done), 0);
      start = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         set_faults(3);
         run_sweep("rand", 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
